stage_sequencer: RTL and testbench

- Multi-cycle stage controller for the MUSA core.
- Steps each instruction through IF/ID/EX/MEM/WB, drives per-stage enables and the 3-bit `stage` code that unit_Control consumes.
- Holds EX for multi-cycle MUL/DIV and waits on a memory handshake for fetch and load/store.
- Handles HALT with an explicit resume.

---
 rtl/musa_seq_pkg.sv | 55 +++++
 rtl/seq_wait_counter.sv | 66 ++++++
 rtl/stage_sequencer.sv | 168 ++++++++++++++++
 tb/tb_stage_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/musa_seq_pkg.sv
// Shared definitions for the MUSA stage sequencer: stage codes, opcodes and opcode classes.
package musa_seq_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EX   = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b101,
        ST_BOOT = 3'b110
    } state_e;

    localparam logic [5:0] OP_LOGICAS = 6'b000000;
    localparam logic [5:0] OP_MUL     = 6'b011100;
    localparam logic [5:0] OP_DIV     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_SUBI    = 6'b001001;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_JR      = 6'b010001;
    localparam logic [5:0] OP_JPC     = 6'b000010;
    localparam logic [5:0] OP_BRFL    = 6'b000100;
    localparam logic [5:0] OP_CALL    = 6'b000011;
    localparam logic [5:0] OP_RET     = 6'b000001;
    localparam logic [5:0] OP_HALT    = 6'b111111;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_MULDIV = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_HALT   = 3'd6
    } op_class_e;

    // Unknown opcodes fall into the ALU class so they retire through WB.
    function automatic op_class_e op_class(input logic [5:0] op);
        op_class_e cls;
        case (op)
            OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
            OP_LW:                           cls = CLS_LOAD;
            OP_SW:                           cls = CLS_STORE;
            OP_JPC, OP_CALL, OP_RET, OP_JR:  cls = CLS_JUMP;
            OP_BRFL:                         cls = CLS_BRANCH;
            OP_HALT:                         cls = CLS_HALT;
            default:                         cls = CLS_ALU;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// MUL/DIV hold-down counter plus the memory-wait watchdog counter (SEQ_WATCHDOG_EN only).
module seq_wait_counter #(
    parameter int MULDIV_LAT = 4
`ifdef SEQ_WATCHDOG_EN
    ,
    parameter int WDOG_LIMIT = 255
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic muldiv_load,
    input  logic muldiv_dec,
    output logic muldiv_zero
`ifdef SEQ_WATCHDOG_EN
    ,
    input  logic wdog_clr,
    input  logic wdog_inc,
    output logic wdog_hit
`endif
);

    logic [3:0] muldiv_cnt_q, muldiv_cnt_d;

    // Load with LAT-1 so EX residency equals MULDIV_LAT including the final zero cycle.
    always_comb begin
        muldiv_cnt_d = muldiv_cnt_q;
        if (muldiv_load) begin
            muldiv_cnt_d = 4'(MULDIV_LAT - 1);
        end else if (muldiv_dec && (muldiv_cnt_q != 4'd0)) begin
            muldiv_cnt_d = muldiv_cnt_q - 4'd1;
        end else begin
            muldiv_cnt_d = muldiv_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) muldiv_cnt_q <= 4'd0;
        else     muldiv_cnt_q <= muldiv_cnt_d;
    end

    assign muldiv_zero = (muldiv_cnt_q == 4'd0);

`ifdef SEQ_WATCHDOG_EN
    logic [7:0] wdog_cnt_q, wdog_cnt_d;

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (wdog_clr) begin
            wdog_cnt_d = 8'd0;
        end else if (wdog_inc) begin
            wdog_cnt_d = wdog_cnt_q + 8'd1;
        end else begin
            wdog_cnt_d = wdog_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wdog_cnt_q <= 8'd0;
        else     wdog_cnt_q <= wdog_cnt_d;
    end

    // Fires on the wait cycle whose increment would reach the limit.
    assign wdog_hit = wdog_inc && (wdog_cnt_q == 8'(WDOG_LIMIT - 1));
`endif

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB controller for the MUSA core.
// Optional memory-wait watchdog with sticky fault: define SEQ_WATCHDOG_EN.
module stage_sequencer
    import musa_seq_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int WDOG_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ack,
    input  logic       branch_taken,
    input  logic       resume,
    output logic [2:0] stage,
    output logic       if_en,
    output logic       id_en,
    output logic       ex_en,
    output logic       mem_en,
    output logic       wb_en,
    output logic       mem_req,
    output logic       pc_write,
    output logic       halted,
    output logic       fault
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       fault_q, fault_d;
    logic       muldiv_load_s, muldiv_dec_s, muldiv_zero_s, wdog_hit_s;
    op_class_e  ex_class_s;

    assign ex_class_s = op_class(op_q);

    // Next-state and Moore output decode; pc_write also looks at mem_ack / branch_taken.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        fault_d       = fault_q;
        muldiv_load_s = 1'b0;
        muldiv_dec_s  = 1'b0;
        if_en         = 1'b0;
        id_en         = 1'b0;
        ex_en         = 1'b0;
        mem_en        = 1'b0;
        wb_en         = 1'b0;
        mem_req       = 1'b0;
        pc_write      = 1'b0;
        halted        = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_IF;
            ST_IF: begin
                if_en   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_write = 1'b1;
                    state_d  = ST_ID;
                end else if (wdog_hit_s) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_ID: begin
                id_en = 1'b1;
                op_d  = opcode;
                if (op_class(opcode) == CLS_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d       = ST_EX;
                    muldiv_load_s = (op_class(opcode) == CLS_MULDIV);
                end
            end
            ST_EX: begin
                ex_en = 1'b1;
                case (ex_class_s)
                    CLS_MULDIV: begin
                        if (muldiv_zero_s) begin
                            state_d = ST_WB;
                        end else begin
                            muldiv_dec_s = 1'b1;
                            state_d      = ST_EX;
                        end
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_JUMP: begin
                        pc_write = 1'b1;
                        state_d  = ST_IF;
                    end
                    CLS_BRANCH: begin
                        pc_write = branch_taken;
                        state_d  = ST_IF;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_en  = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = (ex_class_s == CLS_LOAD) ? ST_WB : ST_IF;
                end else if (wdog_hit_s) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                wb_en   = 1'b1;
                state_d = ST_IF;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (resume && !fault_q) state_d = ST_IF;
                else                    state_d = ST_HALT;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State, latched opcode and sticky fault; async reset also drops mem_req immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            op_q    <= 6'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fault_q <= fault_d;
        end
    end

    assign stage = state_q;

`ifdef SEQ_WATCHDOG_EN
    logic wdog_clr_s, wdog_inc_s;
    assign wdog_clr_s = (state_d != state_q);
    assign wdog_inc_s = mem_req && !mem_ack;
    assign fault      = fault_q;
`else
    assign wdog_hit_s = 1'b0;
    assign fault      = 1'b0;
`endif

    seq_wait_counter #(
        .MULDIV_LAT (MULDIV_LAT)
`ifdef SEQ_WATCHDOG_EN
        ,
        .WDOG_LIMIT (WDOG_LIMIT)
`endif
    ) u_wait_counter (
        .clk         (clk),
        .rst         (rst),
        .muldiv_load (muldiv_load_s),
        .muldiv_dec  (muldiv_dec_s),
        .muldiv_zero (muldiv_zero_s)
`ifdef SEQ_WATCHDOG_EN
        ,
        .wdog_clr    (wdog_clr_s),
        .wdog_inc    (wdog_inc_s),
        .wdog_hit    (wdog_hit_s)
`endif
    );

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed, table-driven bench for stage_sequencer (MULDIV_LAT=4, WDOG_LIMIT=8).
module tb_stage_sequencer;

    localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EX = 3'b010, S_MEM = 3'b011;
    localparam logic [2:0] S_WB = 3'b100, S_HALT = 3'b101, S_BOOT = 3'b110;
    localparam logic [4:0] E_NONE = 5'b00000, E_IF = 5'b10000, E_ID = 5'b01000;
    localparam logic [4:0] E_EX = 5'b00100, E_MEM = 5'b00010, E_WB = 5'b00001;
    localparam logic [5:0] O_R = 6'b000000, O_MUL = 6'b011100, O_DIV = 6'b000101;
    localparam logic [5:0] O_LW = 6'b100011, O_SW = 6'b101011, O_JPC = 6'b000010;
    localparam logic [5:0] O_BRFL = 6'b000100, O_HALT = 6'b111111, O_ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ack = 1'b0, branch_taken = 1'b0, resume = 1'b0;
    logic [2:0] stage;
    logic       if_en, id_en, ex_en, mem_en, wb_en, mem_req, pc_write, halted, fault;

    stage_sequencer #(.MULDIV_LAT(4), .WDOG_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ack(mem_ack),
        .branch_taken(branch_taken), .resume(resume), .stage(stage),
        .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .mem_req(mem_req), .pc_write(pc_write), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       ack, br, res;
        logic [2:0] stg;
        logic [4:0] en;
        logic       req, pcw, hlt;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    function automatic void add(input logic r, input logic [5:0] op, input logic ack,
                                input logic br, input logic res, input logic [2:0] stg,
                                input logic [4:0] en, input logic req, input logic pcw,
                                input logic hlt);
        vec_t v;
        v.rst = r; v.op = op; v.ack = ack; v.br = br; v.res = res;
        v.stg = stg; v.en = en; v.req = req; v.pcw = pcw; v.hlt = hlt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs just after the rising edge, return at the falling edge.
    task automatic step(input logic r, input logic [5:0] op, input logic ack,
                        input logic br, input logic res);
        @(posedge clk);
        #1;
        rst = r; opcode = op; mem_ack = ack; branch_taken = br; resume = res;
        @(negedge clk);
    endtask

    initial begin
        // reset 3 cycles, then BOOT
        for (int i = 0; i < 3; i++) add(1, O_R, 1, 0, 0, S_BOOT, E_NONE, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_BOOT, E_NONE, 0, 0, 0);
        // ALU: IF ID EX WB
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_R, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_EX, E_EX, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_WB, E_WB, 0, 0, 0);
        // LW with two data-wait cycles
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_LW, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_EX, E_EX, 0, 0, 0);
        add(0, O_R, 0, 0, 0, S_MEM, E_MEM, 1, 0, 0);
        add(0, O_R, 0, 0, 0, S_MEM, E_MEM, 1, 0, 0);
        add(0, O_R, 1, 0, 0, S_MEM, E_MEM, 1, 0, 0);
        add(0, O_R, 1, 0, 0, S_WB, E_WB, 0, 0, 0);
        // MUL: 4 EX cycles; opcode input changes during EX must not matter
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_MUL, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, O_HALT, 1, 0, 0, S_EX, E_EX, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_WB, E_WB, 0, 0, 0);
        // DIV: same shape
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_DIV, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, O_R, 1, 0, 0, S_EX, E_EX, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_WB, E_WB, 0, 0, 0);
        // BRFL not taken, then taken
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_BRFL, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_EX, E_EX, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_BRFL, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        add(0, O_R, 1, 1, 0, S_EX, E_EX, 0, 1, 0);
        // JPC: no WB
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_JPC, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_EX, E_EX, 0, 1, 0);
        // SW, resume in EX has no effect, MEM -> IF
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_SW, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        add(0, O_R, 1, 0, 1, S_EX, E_EX, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_MEM, E_MEM, 1, 0, 0);
        // HALT (resume in ID ignored), 10 halted cycles, then resume
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_HALT, 1, 0, 1, S_ID, E_ID, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, O_R, 1, 0, 0, S_HALT, E_NONE, 0, 0, 1);
        add(0, O_R, 0, 0, 1, S_HALT, E_NONE, 0, 0, 1);
        // IF with one fetch wait, then ADDI
        add(0, O_R, 0, 0, 0, S_IF, E_IF, 1, 0, 0);
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_ADDI, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_EX, E_EX, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_WB, E_WB, 0, 0, 0);
        // LW into a stalled MEM, then reset mid-MEM below
        add(0, O_R, 1, 0, 0, S_IF, E_IF, 1, 1, 0);
        add(0, O_LW, 1, 0, 0, S_ID, E_ID, 0, 0, 0);
        add(0, O_R, 1, 0, 0, S_EX, E_EX, 0, 0, 0);
        add(0, O_R, 0, 0, 0, S_MEM, E_MEM, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].ack, vecs[i].br, vecs[i].res);
            chk($sformatf("row%0d.stage", i), {5'd0, stage}, {5'd0, vecs[i].stg});
            chk($sformatf("row%0d.en", i), {3'd0, if_en, id_en, ex_en, mem_en, wb_en},
                {3'd0, vecs[i].en});
            chk($sformatf("row%0d.mem_req", i), {7'd0, mem_req}, {7'd0, vecs[i].req});
            chk($sformatf("row%0d.pc_write", i), {7'd0, pc_write}, {7'd0, vecs[i].pcw});
            chk($sformatf("row%0d.halted", i), {7'd0, halted}, {7'd0, vecs[i].hlt});
            chk($sformatf("row%0d.fault", i), {7'd0, fault}, 8'd0);
        end

        // async reset between clock edges drops mem_req at once
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.mem_req", {7'd0, mem_req}, 8'd0);
        chk("async_rst.stage", {5'd0, stage}, {5'd0, S_BOOT});
        step(0, O_R, 1, 0, 0);
        chk("post_rst.boot", {5'd0, stage}, {5'd0, S_BOOT});
        step(0, O_R, 1, 0, 0);
        chk("post_rst.if", {5'd0, stage}, {5'd0, S_IF});

`ifdef SEQ_WATCHDOG_EN
        step(1, O_R, 0, 0, 0);
        step(0, O_R, 0, 0, 0);
        chk("wdog.boot", {5'd0, stage}, {5'd0, S_BOOT});
        for (int k = 1; k <= 8; k++) begin
            step(0, O_R, 0, 0, 0);
            chk($sformatf("wdog.if%0d", k), {5'd0, stage}, {5'd0, S_IF});
            chk($sformatf("wdog.nofault%0d", k), {7'd0, fault}, 8'd0);
        end
        step(0, O_R, 0, 0, 0);
        chk("wdog.halt", {5'd0, stage}, {5'd0, S_HALT});
        chk("wdog.fault", {7'd0, fault}, 8'd1);
        for (int k = 0; k < 3; k++) begin
            step(0, O_R, 0, 0, 1);
            chk($sformatf("wdog.resume_ignored%0d", k), {5'd0, stage}, {5'd0, S_HALT});
            chk($sformatf("wdog.fault_sticky%0d", k), {7'd0, fault}, 8'd1);
        end
        step(1, O_R, 0, 0, 0);
        chk("wdog.rst_clears", {7'd0, fault}, 8'd0);
        chk("wdog.rst_boot", {5'd0, stage}, {5'd0, S_BOOT});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
